// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory unit: FSM states, RV32I funct3 codes,
// byte-enable width and the funct3 legality helper.
package dmem_pkg;

  localparam int unsigned DMEM_XLEN = 32;
  localparam int unsigned BE_W      = DMEM_XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only make sense for loads.
  function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!write) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return !ok;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response valid-ready bus between the core and the data memory unit.
interface dmem_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte-enables/shifted data, misalign flag,
// and sign/zero extension of load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           lane,
  input  logic [DMEM_XLEN-1:0] wdata,
  input  logic [DMEM_XLEN-1:0] rword,
  output logic [BE_W-1:0]      be,
  output logic [DMEM_XLEN-1:0] wdata_sh,
  output logic                 misalign,
  output logic [DMEM_XLEN-1:0] rdata_ext
);

  logic [DMEM_XLEN-1:0] rshift;

  always_comb begin
    be        = '0;
    misalign  = 1'b0;
    wdata_sh  = wdata << {lane, 3'b000};
    rshift    = rword >> {lane, 3'b000};
    rdata_ext = '0;
    case (funct3)
      F3_B: begin
        be        = BE_W'(1) << lane;
        rdata_ext = {{24{rshift[7]}}, rshift[7:0]};
      end
      F3_BU: begin
        be        = BE_W'(1) << lane;
        rdata_ext = {24'h0, rshift[7:0]};
      end
      F3_H: begin
        be        = BE_W'(3) << lane;
        misalign  = lane[0];
        rdata_ext = {{16{rshift[15]}}, rshift[15:0]};
      end
      F3_HU: begin
        be        = BE_W'(3) << lane;
        misalign  = lane[0];
        rdata_ext = {16'h0, rshift[15:0]};
      end
      F3_W: begin
        be        = '1;
        misalign  = (lane != 2'b00);
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressed RV32I load/store unit with valid/ready handshakes and LATENCY-cycle access.
// Optional access counters enabled with `define DMEM_STATS_EN.
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN        = DMEM_XLEN,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  dmem_if.slave       bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  localparam int unsigned     AW         = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(4 * DEPTH_WORDS);
  localparam logic [3:0]      CNT_INIT   = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  dmem_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic            acc_write;
  logic [2:0]      acc_f3;
  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] acc_wdata;
  logic [AW-1:0]   acc_idx;
  logic            acc_err;
  logic            enter_resp;
  logic            mem_we;

  logic [BE_W-1:0] be;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] rdata_ext;
  logic            misalign;

  // With LATENCY=1 the access happens on the accepting edge, so operands come
  // straight from the bus; otherwise from the latched request.
  always_comb begin
    if (state_q == IDLE) begin
      acc_write = bus.req_write;
      acc_f3    = bus.req_funct3;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_write = wr_q;
      acc_f3    = f3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];
  assign acc_err = misalign || (acc_addr >= ADDR_LIMIT) || f3_illegal(acc_write, acc_f3);

  dmem_lane_align u_lane_align (
    .funct3    (acc_f3),
    .lane      (acc_addr[1:0]),
    .wdata     (acc_wdata),
    .rword     (mem_q[acc_idx]),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .misalign  (misalign),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_write) ? '0 : rdata_ext;
    end
  end

  assign mem_we        = enter_resp && acc_write && !acc_err;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (be[b]) mem_q[acc_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads_q, stat_loads_d;
  logic [31:0] stat_stores_q, stat_stores_d;
  logic [31:0] stat_errs_q, stat_errs_d;

  always_comb begin
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_errs_d   = stat_errs_q;
    if (enter_resp) begin
      if (acc_err)        stat_errs_d   = stat_errs_q + 32'd1;
      else if (acc_write) stat_stores_d = stat_stores_q + 32'd1;
      else                stat_loads_d  = stat_loads_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule
